// File: rtl/decim_frame_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------------------------
// decim_frame_writer: keeps every ROW_DECIM-th line, packs pixels into 32-bit words, FIFO'd writes.
// Optional GRAY8_EN: 8-bit luma, four pixels per word (default: RGB565, two pixels per word).
// Revision 1.0
// ---------------------------------------------------------------------------------------------
module decim_frame_writer #(
    parameter int                OUT_W      = 160,
    parameter int                OUT_H      = 120,
    parameter int                ROW_DECIM  = 4,
    parameter int                FIFO_DEPTH = 16,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              line_end,
    input  logic              pix_valid,
    input  logic [23:0]       pix_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              err_overflow
);

`ifdef GRAY8_EN
    localparam int PPW   = 4;
`else
    localparam int PPW   = 2;
`endif
    localparam int PIX_W  = 32 / PPW;
    localparam int WPR    = OUT_W / PPW;
    localparam int LANE_W = $clog2(PPW);
    localparam int COL_W  = $clog2(OUT_W + 1);
    localparam int ROW_W  = $clog2(OUT_H + 1);
    localparam int LINE_W = (ROW_DECIM > 1) ? $clog2(ROW_DECIM) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W  = ADDR_W + 32;

    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(OUT_W);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(OUT_H - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(ROW_DECIM - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PPW - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] WPR_C     = ADDR_W'(WPR);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [LINE_W-1:0] line_cnt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  out_row;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       pack_acc;
    logic [31:0]       word_next;
    logic [PIX_W-1:0]  pix_conv;
    logic [LANE_W-1:0] lane;

    logic              push_v;
    logic [ADDR_W-1:0] push_addr;
    logic [31:0]       push_data;

    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [ENT_W-1:0]  head;

    logic kept;
    logic pix_take;
    logic word_done;
    logic row_end;
    logic fifo_empty;
    logic pop;
    logic push_ok;

`ifdef GRAY8_EN
    logic [15:0] luma_sum;
    assign luma_sum = 16'd77  * {8'd0, pix_data[23:16]}
                    + 16'd150 * {8'd0, pix_data[15:8]}
                    + 16'd29  * {8'd0, pix_data[7:0]};
    assign pix_conv = PIX_W'(luma_sum >> 8);
`else
    logic unused_pix_bits;
    assign unused_pix_bits = ^{pix_data[18:16], pix_data[9:8], pix_data[2:0]};
    assign pix_conv = {pix_data[23:19], pix_data[15:10], pix_data[7:3]};
`endif

    assign kept      = (line_cnt == '0);
    assign lane      = col[LANE_W-1:0];
    assign pix_take  = (state == S_ACTIVE) && pix_valid && kept && (col < COL_MAX);
    assign word_done = pix_take && (lane == LANE_LAST);
    assign row_end   = (state == S_ACTIVE) && line_end;

    assign fifo_empty = (count == '0);
    assign pop        = wr_valid && wr_ready;
    // A full FIFO still takes the word when the head leaves on the same edge.
    assign push_ok    = push_v && ((count < DEPTH_C) || pop);

    always_comb begin
        word_next = pack_acc;
        word_next[int'(lane) * PIX_W +: PIX_W] = pix_conv;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        if (frame_start) begin
            state_next = S_ACTIVE;
        end else begin
            case (state)
                S_IDLE: state_next = S_IDLE;
                S_ACTIVE: begin
                    if (row_end && kept && (out_row == ROW_LAST)) begin
                        state_next = S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (fifo_empty && !push_v) begin
                        state_next = S_IDLE;
                        frame_done = 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            line_cnt     <= '0;
            col          <= '0;
            out_row      <= '0;
            row_base     <= '0;
            word_idx     <= '0;
            pack_acc     <= '0;
            push_v       <= 1'b0;
            push_addr    <= '0;
            push_data    <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end else if (push_v) begin
                err_overflow <= 1'b1;
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop);

            push_v <= word_done;
            if (word_done) begin
                push_addr <= BASE_ADDR + word_idx;
                push_data <= word_next;
            end

            if (pix_take) begin
                col <= col + COL_W'(1);
                if (word_done) begin
                    pack_acc <= '0;
                    word_idx <= word_idx + ADDR_W'(1);
                end else begin
                    pack_acc <= word_next;
                end
            end

            // The line boundary wins over the pixel update so each kept row starts address-aligned.
            if (row_end) begin
                line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + LINE_W'(1);
                col      <= '0;
                if (kept) begin
                    pack_acc <= '0;
                    out_row  <= out_row + ROW_W'(1);
                    row_base <= row_base + WPR_C;
                    word_idx <= row_base + WPR_C;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !frame_start && push_ok) begin
            mem[wr_ptr] <= {push_addr, push_data};
        end
    end

    assign head     = fifo_empty ? '0 : mem[rd_ptr];
    assign wr_valid = !fifo_empty;
    assign wr_addr  = head[ENT_W-1:32];
    assign wr_data  = head[31:0];
    assign busy     = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_decim_frame_writer.sv
`default_nettype none
// Bench for decim_frame_writer: conversion table, hand-written corner sequences, randomized frames.
module tb_decim_frame_writer;

`ifdef GRAY8_EN
    localparam int PPW = 4;
`else
    localparam int PPW = 2;
`endif
    localparam int PW         = 32 / PPW;
    localparam int OUT_W      = 2 * PPW;
    localparam int OUT_H      = 2;
    localparam int ROW_DECIM  = 2;
    localparam int FIFO_DEPTH = 2;
    localparam int ADDR_W     = 16;
    localparam int BASE       = 0;
    localparam int WPR        = OUT_W / PPW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_start = 1'b0;
    logic              line_end = 1'b0;
    logic              pix_valid = 1'b0;
    logic [23:0]       pix_data = '0;
    logic              wr_ready = 1'b0;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              frame_done;
    logic              err_overflow;

    always #5 clk = ~clk;

    decim_frame_writer #(
        .OUT_W(OUT_W), .OUT_H(OUT_H), .ROW_DECIM(ROW_DECIM),
        .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(16'(BASE))
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .line_end(line_end),
        .pix_valid(pix_valid), .pix_data(pix_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .frame_done(frame_done), .err_overflow(err_overflow)
    );

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    bit rnd_rdy = 1'b0;
    logic [47:0] got[$];

    // Reference model: 0 idle, 1 active, 2 flush; queue mirrors expected FIFO contents.
    int          m_state, m_line, m_col, m_row, m_widx;
    logic [31:0] m_acc;
    bit          m_pv, m_err;
    logic [15:0] m_pa;
    logic [31:0] m_pd;
    logic [47:0] m_q[$];

    typedef struct packed {
        logic [3:0][23:0] px;
        logic [31:0]      exp;
    } conv_vec_t;
    conv_vec_t tbl [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] conv(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
`ifdef GRAY8_EN
        return 32'((77 * r + 150 * g + 29 * b) / 256);
`else
        return 32'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
`endif
    endfunction

    task automatic model_clear();
        m_line = 0; m_col = 0; m_row = 0; m_widx = 0;
        m_acc = '0; m_pv = 1'b0; m_err = 1'b0; m_pa = '0; m_pd = '0;
        m_q.delete();
    endtask

    task automatic model_edge(input bit fs, input bit le, input bit pv, input logic [23:0] pd);
        bit pop, accept, kept;
        if (rst) begin
            model_clear();
            m_state = 0;
            return;
        end
        if (fs) begin
            model_clear();
            m_state = 1;
            return;
        end
        if (m_state == 2 && m_q.size() == 0 && !m_pv) m_state = 0;
        pop    = (m_q.size() > 0) && wr_ready;
        accept = (m_q.size() < FIFO_DEPTH) || pop;
        if (pop) void'(m_q.pop_front());
        if (m_pv) begin
            if (accept) m_q.push_back({m_pa, m_pd});
            else m_err = 1'b1;
        end
        m_pv = 1'b0;
        if (m_state == 1) begin
            kept = (m_line % ROW_DECIM) == 0;
            if (pv && kept && m_col < OUT_W) begin
                m_acc[(m_col % PPW) * PW +: PW] = PW'(conv(pd));
                if (m_col % PPW == PPW - 1) begin
                    m_pv = 1'b1;
                    m_pa = 16'(BASE + m_widx);
                    m_pd = m_acc;
                    m_acc = '0;
                    m_widx++;
                end
                m_col++;
            end
            if (le) begin
                m_line++;
                m_col = 0;
                if (kept) begin
                    m_acc = '0;
                    m_row++;
                    m_widx = m_row * OUT_W / PPW;
                    if (m_row == OUT_H) m_state = 2;
                end
            end
        end
    endtask

    task automatic cycle(input bit fs, input bit le, input bit pv, input logic [23:0] pd);
        if (rnd_rdy) wr_ready = ($urandom_range(0, 3) != 0);
        frame_start = fs; line_end = le; pix_valid = pv; pix_data = pd;
        #1;
        if (wr_valid === 1'b1 && wr_ready) got.push_back({wr_addr, wr_data});
        @(posedge clk);
        model_edge(fs, le, pv, pd);
        #1;
        frame_start = 1'b0; line_end = 1'b0; pix_valid = 1'b0;
        if (frame_done === 1'b1) done_cnt++;
        chk("wr_valid", 64'(wr_valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) chk("wr_word", 64'({wr_addr, wr_data}), 64'(m_q[0]));
        chk("busy", 64'(busy), 64'(m_state != 0));
        chk("frame_done", 64'(frame_done), 64'(m_state == 2 && m_q.size() == 0 && !m_pv));
        chk("err_overflow", 64'(err_overflow), 64'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 24'($urandom()));
        cycle(1'b0, 1'b1, 1'b0, 24'h0);
    endtask

    task automatic rand_line();
        int n;
        bit merged;
        n = $urandom_range(0, OUT_W + 2);
        merged = 1'b0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) cycle(1'b0, 1'b0, 1'b0, 24'h0);
            merged = (i == n - 1) && ($urandom_range(0, 1) == 1);
            cycle(1'b0, merged, 1'b1, 24'($urandom()));
        end
        if (!merged) cycle(1'b0, 1'b1, 1'b0, 24'h0);
    endtask

    initial begin
        int nlines;
`ifdef GRAY8_EN
        tbl[0] = '{px: {24'h000000, 24'h808080, 24'h000000, 24'hFFFFFF}, exp: 32'h008000FF};
        tbl[1] = '{px: {24'h000000, 24'h0000FF, 24'h00FF00, 24'hFF0000}, exp: 32'h001C954C};
        tbl[2] = '{px: {24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000}, exp: 32'hFF000000};
        tbl[3] = '{px: {24'h000000, 24'h000000, 24'h000000, 24'h123456}, exp: 32'h0000002D};
`else
        tbl[0] = '{px: {24'h000000, 24'h000000, 24'h00FF00, 24'hFF0000}, exp: 32'h07E0F800};
        tbl[1] = '{px: {24'h000000, 24'h000000, 24'h000000, 24'hFFFFFF}, exp: 32'h0000FFFF};
        tbl[2] = '{px: {24'h000000, 24'h000000, 24'h000000, 24'h0000FF}, exp: 32'h0000001F};
        tbl[3] = '{px: {24'h000000, 24'h000000, 24'h808080, 24'h123456}, exp: 32'h841011AA};
`endif
        m_state = 0;
        model_clear();

        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("reset_wr_valid", 64'(wr_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_err", 64'(err_overflow), 64'd0);
        chk("reset_word", 64'({wr_addr, wr_data}), 64'd0);

        // Basic frame: four lines, rows 0 and 2 kept.
        wr_ready = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 24'h0);
        got.delete(); done_cnt = 0;
        for (int l = 0; l < 4; l++) send_line(OUT_W);
        idle(6);
        chk("basic_count", 64'(got.size()), 64'(2 * WPR));
        for (int i = 0; i < got.size(); i++) chk("basic_addr", 64'(got[i][47:32]), 64'(BASE + i));
        chk("basic_done", 64'(done_cnt), 64'd1);
        chk("basic_busy", 64'(busy), 64'd0);

        // Conversion table.
        for (int t = 0; t < 4; t++) begin
            cycle(1'b1, 1'b0, 1'b0, 24'h0);
            got.delete();
            for (int p = 0; p < 4; p++) cycle(1'b0, 1'b0, 1'b1, tbl[t].px[p]);
            idle(3);
            if (got.size() == 0) chk("conv_present", 64'd0, 64'd1);
            else chk("conv_data", 64'(got[0][31:0]), 64'(tbl[t].exp));
        end

        // Backpressure: row 0 fills the FIFO, row 2 words are dropped.
        wr_ready = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 24'h0);
        got.delete(); done_cnt = 0;
        send_line(OUT_W);
        send_line(1);
        send_line(OUT_W);
        idle(5);
        chk("bp_err", 64'(err_overflow), 64'd1);
        chk("bp_no_done", 64'(done_cnt), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        wr_ready = 1'b1;
        idle(8);
        chk("bp_count", 64'(got.size()), 64'd2);
        for (int i = 0; i < got.size(); i++) chk("bp_addr", 64'(got[i][47:32]), 64'(BASE + i));
        chk("bp_done", 64'(done_cnt), 64'd1);

        // Short kept row: partial word discarded, next kept row stays aligned.
        cycle(1'b1, 1'b0, 1'b0, 24'h0);
        got.delete();
        send_line(PPW + 1);
        send_line(OUT_W);
        send_line(OUT_W);
        idle(6);
        chk("short_count", 64'(got.size()), 64'(1 + WPR));
        if (got.size() >= 2) begin
            chk("short_addr0", 64'(got[0][47:32]), 64'(BASE));
            chk("short_addr1", 64'(got[1][47:32]), 64'(BASE + WPR));
        end

        // Mid-frame restart with a full FIFO and a dropped word.
        wr_ready = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 24'h0);
        send_line(OUT_W);
        send_line(0);
        for (int p = 0; p < PPW; p++) cycle(1'b0, 1'b0, 1'b1, 24'($urandom()));
        idle(2);
        chk("rs_err_before", 64'(err_overflow), 64'd1);
        chk("rs_full", 64'(wr_valid), 64'd1);
        cycle(1'b1, 1'b0, 1'b0, 24'h0);
        chk("rs_wr_valid", 64'(wr_valid), 64'd0);
        chk("rs_err", 64'(err_overflow), 64'd0);
        wr_ready = 1'b1;
        got.delete();
        for (int p = 0; p < PPW; p++) cycle(1'b0, 1'b0, 1'b1, 24'($urandom()));
        idle(3);
        if (got.size() == 0) chk("rs_present", 64'd0, 64'd1);
        else chk("rs_addr", 64'(got[0][47:32]), 64'(BASE));

        // Randomized frames against the model.
        rnd_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            cycle(1'b1, 1'b0, 1'b0, 24'h0);
            nlines = $urandom_range(1, 5);
            for (int l = 0; l < nlines; l++) begin
                if ($urandom_range(0, 15) == 0) cycle(1'b1, 1'b0, 1'b0, 24'h0);
                rand_line();
            end
            for (int k = 0; k < 60 && m_state == 2; k++) idle(1);
            if (m_state == 2) chk("drain_timeout", 64'(busy), 64'd0);
        end
        rnd_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
